// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_ctrl_pkg;

  // Default byte width on request ports and tx_data
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Frame sequencer states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StStart = 2'd2,
    StWait  = 2'd3
  } tx_state_e;

  // Width of an index into n items (at least one bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr+1, wrapping.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  input  logic                    en,
  output logic [N_REQ-1:0]        gnt,
  output logic [idx_w(N_REQ)-1:0] gnt_idx
);

  localparam int unsigned IW = idx_w(N_REQ);

  logic [IW-1:0] idx;
  logic          found;

  // Scan N_REQ positions starting just after the last owner; the last owner is checked last
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = IW'((32'(ptr) + off) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = en;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte requesters.
// Optional frame timeout: define UART_TX_ARB_TIMEOUT_EN to build the abort counter.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned BITS           = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                      p_clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [BITS-1:0]           cfg_counts,
  input  logic                      cfg_enable,
  output logic [BITS-1:0]           baud_counts,
  output logic                      baud_enable,
  input  logic                      tick,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_dv,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic [N_REQ-1:0]          frame_done,
  output logic                      timeout_err
);

  localparam int unsigned IW = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  tx_state_e     state_q;
  logic [IW-1:0] ptr_q;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             arb_en;

  // Ready is only offered in IDLE and is forced low while reset is held
  assign arb_en    = (state_q == StIdle) && !reset;
  assign req_ready = gnt;
  assign busy      = (state_q != StIdle);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Frame sequencer with registered handshake outputs and baud config shadow
  always_ff @(posedge p_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      tx_data     <= '0;
      tx_dv       <= 1'b0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      frame_done  <= '0;
      baud_counts <= '0;
      baud_enable <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      tx_dv      <= 1'b0;
      frame_done <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          // Baud config only moves between frames so a frame never sees a rate change
          baud_counts <= cfg_counts;
          baud_enable <= cfg_enable;
          if (|req_valid) begin
            tx_data  <= req_data[gnt_idx*DATA_W +: DATA_W];
            grant_id <= gnt_idx;
            tx_dv    <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          tx_start <= 1'b1;
          state_q  <= StStart;
        end
        StStart: begin
          if (tick) begin
            tx_start <= 1'b0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (tx_done) begin
            frame_done[grant_id] <= 1'b1;
            ptr_q                <= grant_id;
            state_q              <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
      // Counter spans START and WAIT; an abort overrides the normal transition
      if (state_q == StLoad) begin
        tmo_cnt_q <= '0;
      end else if (state_q == StStart || state_q == StWait) begin
        if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1) && !(state_q == StWait && tx_done)) begin
          tx_start      <= 1'b0;
          timeout_err_q <= 1'b1;
          ptr_q         <= grant_id;
          state_q       <= StIdle;
          tmo_cnt_q     <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

endmodule
